// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Multi-cycle instruction controller: accepts one instruction at a time in IDLE,
// decodes it, and steps it through EXEC, an optional data-memory phase (MEM), and
// write-back (WB). All control outputs are registered Moore outputs. The decoded
// operand fields are captured at the end of DECODE and held until the next DECODE.
//
// Optional feature (macro CTRL_ILLEGAL_TRAP_EN): class 4'b1111 is trapped as illegal.
// It goes DECODE->WB directly, raises the extra port 'illegal' with done, and writes
// nothing. With the macro undefined, class 4'b1111 runs as an ordinary ALU op.
//
// Parameters:
//   INSTR_W  instruction width (32..64)
//   REG_AW   register address width (1..6)
//   IMM_W    immediate width (1..INSTR_W-17)
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   instr, instr_valid      offered instruction
//   instr_ready             controller accepts instr this cycle (IDLE only)
//   mem_ready               data memory completed the current access (sampled in MEM)
//   mem_req, memwrite       data-memory access in progress / store access
//   alu_opsel, alu_mode     ALU controls
//   mux_sel1, mux_sel2      datapath operand selects
//   rs, rt, rd, imm         decoded operand fields
//   regwrite, done          write-back pulse / instruction complete pulse
//   illegal                 illegal-class pulse with done (CTRL_ILLEGAL_TRAP_EN only)
//   busy                    high in every state except IDLE

module multicycle_controller #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned REG_AW  = 6,
    parameter int unsigned IMM_W   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic [2:0]         alu_opsel,
    output logic               alu_mode,
    output logic               mux_sel1,
    output logic               mux_sel2,
    output logic [REG_AW-1:0]  rs,
    output logic [REG_AW-1:0]  rt,
    output logic [REG_AW-1:0]  rd,
    output logic [IMM_W-1:0]   imm,
    output logic               regwrite,
    output logic               memwrite,
    output logic               done,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output logic               busy
);

    localparam logic [3:0] ClassLoad    = 4'b0100;
    localparam logic [3:0] ClassStore   = 4'b0110;
    localparam logic [3:0] ClassIllegal = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [3:0]           class_q, class_d;
    logic                 is_load, is_store, is_illegal;

    logic instr_ready_q, instr_ready_d;
    logic busy_q, busy_d;
    logic mem_req_q, mem_req_d;
    logic memwrite_q, memwrite_d;
    logic regwrite_q, regwrite_d;
    logic done_q, done_d;

    // Next-state and next-output logic. The class seen here is the one that will be
    // valid after this edge, so an illegal op can pick its WB outputs while still
    // in DECODE.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        class_d = class_q;

        if (state_q == StDecode) begin
            class_d = instr_q[16:13];
        end

        is_load  = (class_d == ClassLoad);
        is_store = (class_d == ClassStore);
`ifdef CTRL_ILLEGAL_TRAP_EN
        is_illegal = (class_d == ClassIllegal);
`else
        is_illegal = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = is_illegal ? StWb : StExec;
            StExec:   state_d = (is_load || is_store) ? StMem : StWb;
            StMem: begin
                if (mem_ready) begin
                    state_d = StWb;
                end
            end
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        instr_ready_d = (state_d == StIdle);
        busy_d        = (state_d != StIdle);
        mem_req_d     = (state_d == StMem);
        memwrite_d    = mem_req_d && is_store;
        done_d        = (state_d == StWb);
        regwrite_d    = done_d && !is_store && !is_illegal;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            instr_q       <= '0;
            class_q       <= '0;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            regwrite_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            class_q       <= class_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            mem_req_q     <= mem_req_d;
            memwrite_q    <= memwrite_d;
            regwrite_q    <= regwrite_d;
            done_q        <= done_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= done_d && is_illegal;
        end
    end

    assign illegal = illegal_q;
`endif

    // Decoded fields: captured only at the end of DECODE, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_opsel <= '0;
            alu_mode  <= 1'b0;
            mux_sel1  <= 1'b0;
            mux_sel2  <= 1'b0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            imm       <= '0;
        end else if (state_q == StDecode) begin
            alu_opsel <= instr_q[16:14];
            alu_mode  <= instr_q[12];
            mux_sel1  <= instr_q[0];
            mux_sel2  <= (instr_q[16:13] == ClassLoad) || (instr_q[16:13] == ClassStore);
            rs        <= instr_q[1 +: REG_AW];
            rd        <= instr_q[7 +: REG_AW];
            rt        <= instr_q[17 +: REG_AW];
            imm       <= instr_q[INSTR_W-1 -: IMM_W];
        end
    end

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign mem_req     = mem_req_q;
    assign memwrite    = memwrite_q;
    assign regwrite    = regwrite_q;
    assign done        = done_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A transaction-level model predicts,
// for each instruction and memory wait count, the cycle-by-cycle control outputs and
// the decoded fields. A second instance with REG_AW=4, IMM_W=8 shares the stimulus.

module tb_multicycle_controller;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_ready;

    logic        instr_ready, mem_req, alu_mode, mux_sel1, mux_sel2;
    logic [2:0]  alu_opsel;
    logic [5:0]  rs, rt, rd;
    logic [14:0] imm;
    logic        regwrite, memwrite, done, busy, ill_a;

    logic        b_instr_ready, b_mem_req, b_alu_mode, b_mux_sel1, b_mux_sel2;
    logic [2:0]  b_alu_opsel;
    logic [3:0]  b_rs, b_rt, b_rd;
    logic [7:0]  b_imm;
    logic        b_regwrite, b_memwrite, b_done, b_busy, ill_b;

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .mem_req(mem_req),
        .alu_opsel(alu_opsel), .alu_mode(alu_mode), .mux_sel1(mux_sel1),
        .mux_sel2(mux_sel2), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .regwrite(regwrite), .memwrite(memwrite), .done(done),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal(ill_a),
`endif
        .busy(busy)
    );

    multicycle_controller #(.INSTR_W(32), .REG_AW(4), .IMM_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(b_instr_ready), .mem_ready(mem_ready), .mem_req(b_mem_req),
        .alu_opsel(b_alu_opsel), .alu_mode(b_alu_mode), .mux_sel1(b_mux_sel1),
        .mux_sel2(b_mux_sel2), .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm(b_imm),
        .regwrite(b_regwrite), .memwrite(b_memwrite), .done(b_done),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal(ill_b),
`endif
        .busy(b_busy)
    );

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign ill_a = 1'b0;
    assign ill_b = 1'b0;
`endif

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] prev_ins = '0;  // instruction whose fields are currently on the outputs

    typedef struct {
        logic [31:0] ins;
        int          nwait;
        bit          hold;
        int          exp_lat;
        int          exp_memc;
        logic        exp_mux2;
        logic        exp_regwr;
    } vec_t;

    function automatic logic [38:0] fields_of(input logic [31:0] w);
        logic [3:0] c;
        c = w[16:13];
        return {w[16:14], w[12], w[0], (c == 4'b0100) || (c == 4'b0110),
                w[6:1], w[22:17], w[12:7], w[31:17]};
    endfunction

    function automatic logic [11:0] fields_b_of(input logic [31:0] w);
        return {w[20:17], w[31:24]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_a();
        return {instr_ready, busy, mem_req, memwrite, regwrite, done, ill_a};
    endfunction

    function automatic logic [6:0] ctrl_b();
        return {b_instr_ready, b_busy, b_mem_req, b_memwrite, b_regwrite, b_done, ill_b};
    endfunction

    function automatic logic [38:0] obs_fields();
        return {alu_opsel, alu_mode, mux_sel1, mux_sel2, rs, rt, rd, imm};
    endfunction

    // Entered at posedge+1 with the DUT idle; leaves at posedge+1 after WB.
    task automatic do_instr(input logic [31:0] ins, input int nwait, input bit hold,
                            output int lat, output int memc, output int regwr_cnt);
        logic [3:0] cls;
        bit         st, ill, is_mem, in_mem, wb;
        int         total;
        logic [6:0] exp_ctrl;
        cls    = ins[16:13];
        st     = (cls == 4'b0110);
        is_mem = (cls == 4'b0100) || st;
        ill    = Trap && (cls == 4'b1111);
        total  = ill ? 2 : (is_mem ? 4 + nwait : 3);
        lat = -1; memc = 0; regwr_cnt = 0;
        for (int k = 0; k <= total; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            instr_valid = (k == 0) ? 1'b1 : ((k == total && hold) ? 1'b1 : 1'($urandom_range(0, 1)));
            instr       = (k == 0) ? ins : $urandom;
            in_mem      = is_mem && (k >= 3) && (k <= 3 + nwait);
            mem_ready   = in_mem ? (k == 3 + nwait) : 1'($urandom_range(0, 1));
            @(negedge clk);
            wb       = (k == total);
            exp_ctrl = {k == 0, k != 0, in_mem, in_mem && st, wb && !st && !ill, wb, wb && ill};
            check("ctrl", 64'(ctrl_a()), 64'(exp_ctrl));
            check("ctrl_b", 64'(ctrl_b()), 64'(exp_ctrl));
            check("fields", 64'(obs_fields()), 64'(fields_of(k >= 2 ? ins : prev_ins)));
            check("fields_b", 64'({b_rt, b_imm}), 64'(fields_b_of(k >= 2 ? ins : prev_ins)));
            if (done && lat < 0) lat = k;
            if (mem_req) memc++;
            if (regwrite) regwr_cnt++;
        end
        prev_ins = ins;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        int lat, memc, rwc;
        logic [31:0] ins;

        vecs.push_back('{32'h0000_2002, 0, 1'b0, 3, 0, 1'b0, 1'b1});  // ALU reg type
        vecs.push_back('{32'h0000_8001, 3, 1'b1, 7, 4, 1'b1, 1'b1});  // LOAD, 3 waits
        vecs.push_back('{32'h0000_C000, 0, 1'b1, 4, 1, 1'b1, 1'b0});  // STORE, no wait
        vecs.push_back('{32'hABCD_1234, 0, 1'b1, 3, 0, 1'b0, 1'b1});  // ALU, class 1000
        vecs.push_back('{32'hFFF0_8000, 1, 1'b0, 5, 2, 1'b1, 1'b1});  // LOAD, 1 wait
        if (Trap) vecs.push_back('{32'h0001_E000, 0, 1'b1, 2, 0, 1'b0, 1'b0});
        else      vecs.push_back('{32'h0001_E000, 0, 1'b1, 3, 0, 1'b0, 1'b1});

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'(ctrl_a()), 64'(0));
        check("reset_fields", 64'(obs_fields()), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_release_edge", 64'(instr_ready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_release", 64'(ctrl_a()), 64'(7'b1000000));
        @(posedge clk); #1;

        // Table-driven directed vectors, run back to back.
        foreach (vecs[i]) begin
            do_instr(vecs[i].ins, vecs[i].nwait, vecs[i].hold, lat, memc, rwc);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_memcycles", i), 64'(memc), 64'(vecs[i].exp_memc));
            check($sformatf("vec%0d_regwrite", i), 64'(rwc), 64'(vecs[i].exp_regwr));
            check($sformatf("vec%0d_mux_sel2", i), 64'(mux_sel2), 64'(vecs[i].exp_mux2));
        end

        // Reset asserted while waiting in MEM aborts the LOAD.
        instr = 32'h0000_8001; instr_valid = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0; mem_ready = 1'b1;  // ignored in DECODE/EXEC
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("abort_in_mem", 64'({mem_req, busy, done}), 64'(3'b110));
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("abort_still_mem", 64'({mem_req, busy, done}), 64'(3'b110));
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        prev_ins = '0;
        check("abort_ctrl", 64'(ctrl_a()), 64'(0));
        check("abort_fields", 64'(obs_fields()), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_idle_no_done", 64'(ctrl_a()), 64'(7'b1000000));
        @(posedge clk); #1;

        // Randomized instructions against the model, with occasional idle gaps.
        for (int r = 0; r < 40; r++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[16:13] = 4'b0100;
                1: ins[16:13] = 4'b0110;
                2: ins[16:13] = 4'b1111;
                default: ;
            endcase
            do_instr(ins, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), lat, memc, rwc);
            if ($urandom_range(0, 2) == 0) begin
                instr_valid = 1'b0;
                mem_ready   = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("idle_gap", 64'(ctrl_a()), 64'(7'b1000000));
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
